neuron_layer_seq: RTL
=====================

NEURON_LAYER_SEQ -- requirements
Module: neuron_layer_seq

Interface
REQ-001 Parameter N, default 16: inputs per neuron, N >= 2.
REQ-002 Parameter M, default 55: neurons in the layer, M >= 1.
REQ-003 Parameter W, default 8: data width. Data is unsigned, value = x/2^W.
REQ-004 Parameter LR_SHIFT, default 2: learning-rate right shift.
REQ-005 Parameter INIT_W, default 64: reset value of every weight.
REQ-006 Weights are signed, W+2 bits wide, value = w/2^W, range [-2,2).
REQ-007 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port in_valid, input, 1 bit: input sample present.
REQ-010 Port in_ready, output, 1 bit: block can accept a sample.
REQ-011 Port in_data, input, [N-1:0][W-1:0]: input activations.
REQ-012 Port learn, input, 1 bit: this sample also updates weights.
REQ-013 Port expected, input, [M-1:0][W-1:0]: target outputs, used only when learn=1.
REQ-014 Port out_valid, output, 1 bit: result available.
REQ-015 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-016 Port out_data, output, [M-1:0][W-1:0]: neuron outputs.
REQ-017 Port w_load, input, 1 bit: write one weight.
REQ-018 Port w_j, input, clog2(M) bits: weight neuron index (write and read).
REQ-019 Port w_i, input, clog2(N) bits: weight input index (write and read).
REQ-020 Port w_wdata, input, W+2 bits: weight write data.
REQ-021 Port w_rdata, output, W+2 bits: combinational read of weight[w_j][w_i].

Function
REQ-022 Time-multiplexing: one multiply-accumulate unit is shared by all neurons; one MAC per cycle.
REQ-023 FSM states:
- IDLE: in_ready=1.
- MAC: N cycles, i = 0..N-1.
- ACT: 1 cycle.
- UPD: N cycles.
- DONE: out_valid=1.
REQ-024 Input capture, IDLE: in_valid=1 (with in_ready=1) latches in_data, expected and learn, sets j=0 and acc=0, and moves to MAC.
REQ-025 MAC: acc += in[i]*weight[j][i]. The accumulator is signed, width 2W+3+clog2(N), and does not overflow.
REQ-026 ACT: out_data[j] = clamp(acc>>>W, 0, 2^W-1).
REQ-027 ACT next state:
- learn=1: UPD.
- learn=0, j<M-1: MAC with j+1, acc=0.
- learn=0, j=M-1: DONE.
REQ-028 UPD, cycle i:
- e = expected[j] - out_data[j], signed W+1 bits.
- weight[j][i] += (e*in[i]) >>> (W+LR_SHIFT), saturated to [-2^(W+1), 2^(W+1)-1].
- After i=N-1: next neuron (MAC) or DONE, same rule as REQ-027.
REQ-029 Latency from capture to out_valid: M*(N+1) cycles with learn=0, M*(2N+1) cycles with learn=1.
REQ-030 DONE: out_valid stays 1 and out_data stays stable until out_ready=1; that cycle returns to IDLE. No new sample is accepted while out_valid=1.
REQ-031 in_ready is 1 only in IDLE; in_valid outside IDLE is ignored.
REQ-032 out_data changes only in ACT; entries not yet recomputed keep their previous values.
REQ-033 w_load is honoured only in IDLE and is ignored elsewhere.
REQ-034 If w_load and in_valid occur in the same IDLE cycle, the weight write completes first; the sample then uses the new weight.
REQ-035 Out-of-range w_j or w_i: writes are ignored and w_rdata = 0.

Reset
REQ-036 While rst_n=0, immediately:
- state=IDLE, in_ready=1, out_valid=0.
- out_data all 0, acc=0, j=0, i=0.
- every weight = INIT_W.
REQ-037 Reset mid-operation abandons the sample. Weight updates of the partial pass are lost, because all weights return to INIT_W.

Verification (N=4, M=3, W=8, LR_SHIFT=2, INIT_W=64)
REQ-038 All in=128, learn=0 -> out_valid exactly 15 cycles after capture; out_data = {128,128,128}.
REQ-039 Weights of neuron 0 loaded to -256, all in=128 -> out_data[0]=0 (low clamp); others 128.
REQ-040 All weights 511, all in=255 -> acc=521220; out_data = {255,255,255} (high clamp).
REQ-041 All in=128, expected all 192, learn=1 -> out_valid after 27 cycles; out_data={128,...}; every weight reads 72 via w_rdata.
REQ-042 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-043 rst_n pulsed low during UPD of neuron 1 -> outputs at reset values immediately; every weight reads 64 afterwards.

Source files
------------

// File: rtl/neuron_layer_seq.sv
// Single-layer neuron array sharing one multiply-accumulate unit across all neurons,
// with optional delta-rule weight update per sample and a direct weight load/read port.
module neuron_layer_seq #(
    parameter int N        = 16,
    parameter int M        = 55,
    parameter int W        = 8,
    parameter int LR_SHIFT = 2,
    parameter int INIT_W   = 64,
    localparam int JW      = (M > 1) ? $clog2(M) : 1,
    localparam int IW      = $clog2(N)
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0][W-1:0]   in_data,
    input  logic                  learn,
    input  logic [M-1:0][W-1:0]   expected,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M-1:0][W-1:0]   out_data,
    input  logic                  w_load,
    input  logic [JW-1:0]         w_j,
    input  logic [IW-1:0]         w_i,
    input  logic [W+1:0]          w_wdata,
    output logic [W+1:0]          w_rdata,
    output logic [2:0]            dbg_state
);
    localparam int AW = 2 * W + 3 + $clog2(N);

    // Handshake: a sample transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready.
    typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_DONE} state_t;

    state_t state, state_next;

    logic [N-1:0][W-1:0]  x_q;
    logic [M-1:0][W-1:0]  t_q;
    logic                 learn_q;
    logic [JW-1:0]        j;
    logic [IW-1:0]        i;
    logic signed [AW-1:0] acc;
    logic signed [W+1:0]  weight [M][N];

    logic                  last_i, last_j, w_hit;
    logic signed [W:0]     x_s, err;
    logic signed [W+1:0]   w_cur, w_new;
    logic signed [2*W+2:0] prod, w_sum;
    logic signed [2*W+1:0] eprod, delta;
    logic [W-1:0]          act_val;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        last_i = (i == IW'(N - 1));
        last_j = (j == JW'(M - 1));
        w_hit  = (int'(w_j) < M) && (int'(w_i) < N);
        w_rdata = '0;
        if (w_hit) w_rdata = weight[w_j][w_i];

        x_s   = {1'b0, x_q[i]};
        w_cur = weight[j][i];
        prod  = x_s * w_cur;

        // Error uses the output just written in ACT for this neuron.
        err   = {1'b0, t_q[j]} - {1'b0, out_data[j]};
        eprod = err * x_s;
        delta = eprod >>> (W + LR_SHIFT);
        w_sum = {{(W + 1){w_cur[W+1]}}, w_cur} + {delta[2*W+1], delta};
        if ((&w_sum[2*W+2:W+1]) || !(|w_sum[2*W+2:W+1])) begin
            w_new = w_sum[W+1:0];
        end else if (w_sum[2*W+2]) begin
            w_new = {1'b1, {(W + 1){1'b0}}};
        end else begin
            w_new = {1'b0, {(W + 1){1'b1}}};
        end

        if (acc[AW-1]) begin
            act_val = '0;
        end else if (|acc[AW-2:2*W]) begin
            act_val = '1;
        end else begin
            act_val = acc[2*W-1:W];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = S_MAC;
            S_MAC:  if (last_i) state_next = S_ACT;
            S_ACT: begin
                if (learn_q)     state_next = S_UPD;
                else if (last_j) state_next = S_DONE;
                else             state_next = S_MAC;
            end
            S_UPD: if (last_i) state_next = last_j ? S_DONE : S_MAC;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            t_q      <= '0;
            learn_q  <= 1'b0;
            j        <= '0;
            i        <= '0;
            acc      <= '0;
            out_data <= '0;
            for (int a = 0; a < M; a++) begin
                for (int b = 0; b < N; b++) begin
                    weight[a][b] <= (W + 2)'(INIT_W);
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // The load lands on the capture edge, so the sample sees the new weight.
                    if (w_load && w_hit) weight[w_j][w_i] <= w_wdata;
                    if (in_valid) begin
                        x_q     <= in_data;
                        t_q     <= expected;
                        learn_q <= learn;
                        j       <= '0;
                        i       <= '0;
                        acc     <= '0;
                    end
                end
                S_MAC: begin
                    acc <= acc + {{($clog2(N)){prod[2*W+2]}}, prod};
                    i   <= last_i ? '0 : i + 1'b1;
                end
                S_ACT: begin
                    out_data[j] <= act_val;
                    if (!learn_q) begin
                        acc <= '0;
                        if (!last_j) j <= j + 1'b1;
                    end
                end
                S_UPD: begin
                    weight[j][i] <= w_new;
                    if (last_i) begin
                        i   <= '0;
                        acc <= '0;
                        if (!last_j) j <= j + 1'b1;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
